friscv_dispatcher: RTL and testbench
====================================

# friscv_dispatcher

Issue controller between instruction fetch and the execution units. It accepts one 32-bit RISC-V instruction at a time over a valid/ready handshake and holds it in a single-entry issue register. It classifies the instruction by opcode, tracks in-flight register writes from the processing unit in a scoreboard, and issues the instruction to either the processing port or the control port once no hazard remains.

## Interface
Parameters:
- XLEN, 32, instruction and PC width
- NB_REG, 32, architectural registers tracked by the scoreboard; x0 is never tracked

Ports:
- aclk  in  1  clock
- arst  in  1  asynchronous reset, active high
- flush  in  1  synchronous; drops the held instruction
- inst_valid  in  1  fetch offers an instruction
- inst_ready  out  1  dispatcher accepts the instruction this cycle
- inst  in  XLEN  instruction word
- inst_pc  in  XLEN  PC of the instruction
- proc_valid / proc_ready  out / in  1  processing-port handshake
- ctrl_valid / ctrl_ready  out / in  1  control-port handshake
- issue_inst  out  XLEN  held instruction, shared by both ports
- issue_pc  out  XLEN  held PC, shared by both ports
- ctrl_dec_error  out  1  held instruction has an unsupported opcode; qualified by ctrl_valid
- done_valid  in  1  processing unit retired a register write
- done_rd  in  5  destination register of that retired write
- sb_empty  out  1  no tracked write is in flight

## Operation
Classification, by opcode = inst[6:0]:
- PROC: 0000011 load, 0100011 store, 0010011 OP-IMM, 0110011 OP.
- CTRL: 0110111, 0010111, 1101111, 1100111, 1100011, 1110011, 0001111.
- Any other opcode goes to CTRL with ctrl_dec_error=1.

Register usage, where rs1=inst[19:15], rs2=inst[24:20], rd=inst[11:7]:
- Uses rs1: load, store, OP-IMM, OP, JALR, branch, CSR ops with funct3 in {001, 010, 011}.
- Uses rs2: store, OP, branch.
- Writes rd: all classes except store, branch, fence, and SYSTEM with funct3=000.

Hazards:
- A hazard exists when a used rs1 or rs2, or a written rd, is nonzero and its scoreboard bit is set.
- SYSTEM with funct3=000 and all 0001111 instructions are serializing. They also require sb_empty=1 before issue.

Scoreboard:
- NB_REG bits; bit 0 is hardwired to 0.
- Set: a PROC issue fires (proc_valid & proc_ready) for an instruction that writes a nonzero rd sets busy[rd].
- Clear: done_valid clears busy[done_rd].
- A set and a clear to different registers in the same cycle both take effect.
- A set and a clear to the same register cannot occur, because the WAW hazard blocks that issue.
- done_valid for a register whose bit is already clear is ignored.
- CTRL issues never set bits.

FSM, with state in a register:
- EMPTY: nothing is held. inst_ready=~flush. A handshake loads the issue register and moves to STALL, or to DRAIN if the instruction is serializing.
- STALL: the instruction is held. The port valid is asserted when there is no hazard. On issue fire, go to EMPTY, or reload if a new instruction is accepted in the same cycle.
- DRAIN: the instruction is held until sb_empty=1, then it behaves as in STALL.

Issue rules:
- inst_ready = ~flush & (state==EMPTY | issue_fire), so back-to-back issue at one instruction per cycle is possible.
- Valid depends only on the held instruction and the scoreboard, never on ready. The scoreboard only clears while an instruction waits, so a valid, once high, stays high until its handshake fires. The only exception is flush.
- Flush has priority over everything: it returns the FSM to EMPTY, deasserts both valids next cycle, and forces inst_ready=0 in that cycle.
- A flush in the same cycle as issue_fire still counts the fire, including the scoreboard set.
- Flush never clears the scoreboard.

## Timing
- Reset (arst high) clears, asynchronously: FSM to EMPTY, scoreboard to 0, proc_valid=0, ctrl_valid=0, issue_inst=0, issue_pc=0, ctrl_dec_error=0, sb_empty=1.
- inst_ready is 1 after reset release when flush=0.
- Accept-to-valid latency is 1 cycle when there is no hazard.
- A scoreboard clear is visible to the hazard check on the cycle after done_valid, so there is 1 cycle from done to a dependent valid.
- sb_empty is registered from the scoreboard state and reflects updates one cycle later.
- Combinational paths: proc_ready/ctrl_ready to inst_ready, and flush to inst_ready. No path runs from ready to valid.
- arst asserted mid-operation drops the held instruction and all scoreboard state immediately.

## Test plan
- Independent stream: addi x1,x0,1 then addi x2,x0,2 with proc_ready=1 → proc_valid high on 2 consecutive cycles; busy[1] and busy[2] set; no stall.
- RAW: addi x5,... issued, then add x6,x5,x3 → proc_valid stays low and inst_ready=0 until done_valid/done_rd=5; valid rises exactly 1 cycle after done.
- Fence drain: lw x7 outstanding, then fence → held in DRAIN; ctrl_valid rises 1 cycle after done_rd=7 clears the scoreboard; store and branch never set bits.
- Illegal opcode 0x0000007F → ctrl_valid=1 with ctrl_dec_error=1, scoreboard unchanged; rd=x0 instructions never block.
- Flush while a branch is held and ctrl_ready=0 → ctrl_valid=0 next cycle, inst_ready=0 during the flush cycle, busy bits preserved.
- Backpressure: proc_ready=0 for 5 cycles → proc_valid, issue_inst and issue_pc stable; a reset pulse mid-stall returns all outputs to their reset values.

Source files
------------

// File: rtl/friscv_dispatcher.sv
// friscv_dispatcher: single-entry issue stage between fetch and the execution
// units. Holds one instruction, classifies it by opcode, checks it against a
// scoreboard of in-flight processing-unit writes and issues it to the
// processing or control port once no hazard remains.
//
//   state | meaning
//   EMPTY | nothing held, ready to accept
//   STALL | instruction held, issues as soon as no register hazard remains
//   DRAIN | serializing instruction held, also waits for an empty scoreboard
module friscv_dispatcher #(
   parameter int XLEN   = 32,
   parameter int NB_REG = 32
) (
   input  logic            aclk,
   input  logic            arst,
   input  logic            flush,
   input  logic            inst_valid,
   output logic            inst_ready,
   input  logic [XLEN-1:0] inst,
   input  logic [XLEN-1:0] inst_pc,
   output logic            proc_valid,
   input  logic            proc_ready,
   output logic            ctrl_valid,
   input  logic            ctrl_ready,
   output logic [XLEN-1:0] issue_inst,
   output logic [XLEN-1:0] issue_pc,
   output logic            ctrl_dec_error,
   input  logic            done_valid,
   input  logic [4:0]      done_rd,
   output logic            sb_empty
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   typedef enum logic [1:0] {EMPTY, STALL, DRAIN} state_t;

   state_t            state, state_next;
   logic [NB_REG-1:0] busy, busy_next;
   logic [6:0]        op;
   logic [2:0]        f3;
   logic [4:0]        rs1, rs2, rd;
   logic              is_proc, is_err, use_rs1, use_rs2, use_rd, hazard;
   logic              held, can_issue, proc_fire, issue_fire, accept;

   // Serializing instructions (fence, ecall/ebreak/mret...) must see an empty scoreboard.
   function automatic logic is_serial(input logic [6:0] opc, input logic [2:0] fn3);
      return (opc == OP_FENCE) || (opc == OP_SYSTEM && fn3 == 3'b000);
   endfunction

   assign op  = issue_inst[6:0];
   assign f3  = issue_inst[14:12];
   assign rd  = issue_inst[11:7];
   assign rs1 = issue_inst[19:15];
   assign rs2 = issue_inst[24:20];

   // Decode of the held instruction and register hazard check against the scoreboard.
   always_comb begin
      is_proc = (op == OP_LOAD) || (op == OP_STORE) || (op == OP_IMM) || (op == OP_OP);
      is_err  = !(is_proc || op == OP_LUI || op == OP_AUIPC || op == OP_JAL ||
                  op == OP_JALR || op == OP_BRANCH || op == OP_SYSTEM || op == OP_FENCE);
      use_rs1 = is_proc || op == OP_JALR || op == OP_BRANCH ||
                (op == OP_SYSTEM && (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011));
      use_rs2 = (op == OP_STORE) || (op == OP_OP) || (op == OP_BRANCH);
      use_rd  = !((op == OP_STORE) || (op == OP_BRANCH) || (op == OP_FENCE) ||
                  (op == OP_SYSTEM && f3 == 3'b000));
      hazard  = (use_rs1 && rs1 != 5'd0 && busy[rs1]) ||
                (use_rs2 && rs2 != 5'd0 && busy[rs2]) ||
                (use_rd  && rd  != 5'd0 && busy[rd]);
   end

   // FSM state register.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) state <= EMPTY;
      else      state <= state_next;
   end

   // FSM next state: flush wins; otherwise load on accept, leave on issue.
   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = EMPTY;
      end else begin
         case (state)
            EMPTY: if (accept)
                      state_next = is_serial(inst[6:0], inst[14:12]) ? DRAIN : STALL;
            STALL, DRAIN: if (issue_fire) begin
                      if (accept) state_next = is_serial(inst[6:0], inst[14:12]) ? DRAIN : STALL;
                      else        state_next = EMPTY;
                   end
            default: state_next = EMPTY;
         endcase
      end
   end

   // FSM outputs: valids depend only on the held instruction and scoreboard, never on ready.
   always_comb begin
      held           = (state != EMPTY);
      can_issue      = held && !hazard && (state != DRAIN || sb_empty);
      proc_valid     = can_issue && is_proc;
      ctrl_valid     = can_issue && !is_proc;
      ctrl_dec_error = held && is_err;
      proc_fire      = proc_valid && proc_ready;
      issue_fire     = proc_fire || (ctrl_valid && ctrl_ready);
      inst_ready     = !flush && (state == EMPTY || issue_fire);
      accept         = inst_valid && inst_ready;
   end

   // Scoreboard update: retire clears, processing issue with a real rd sets.
   always_comb begin
      busy_next = busy;
      if (done_valid) busy_next[done_rd] = 1'b0;
      if (proc_fire && use_rd && rd != 5'd0) busy_next[rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   // Scoreboard and its registered empty flag.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         busy     <= '0;
         sb_empty <= 1'b1;
      end else begin
         busy     <= busy_next;
         sb_empty <= ~|busy_next;
      end
   end

   // Issue register loads on every accepted instruction.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         issue_inst <= '0;
         issue_pc   <= '0;
      end else if (accept) begin
         issue_inst <= inst;
         issue_pc   <= inst_pc;
      end
   end

endmodule

// File: tb/tb_friscv_dispatcher.sv
// Directed bench for friscv_dispatcher: a table of single-instruction vectors
// followed by hand-written multi-cycle sequences.
module tb_friscv_dispatcher;

   logic        aclk, arst, flush, inst_valid, inst_ready;
   logic [31:0] inst, inst_pc, issue_inst, issue_pc;
   logic        proc_valid, proc_ready, ctrl_valid, ctrl_ready;
   logic        ctrl_dec_error, done_valid, sb_empty;
   logic [4:0]  done_rd;

   int n_cmp = 0;
   int n_err = 0;

   friscv_dispatcher #(.XLEN(32), .NB_REG(32)) dut (
      .aclk(aclk), .arst(arst), .flush(flush),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst(inst), .inst_pc(inst_pc),
      .proc_valid(proc_valid), .proc_ready(proc_ready),
      .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
      .issue_inst(issue_inst), .issue_pc(issue_pc),
      .ctrl_dec_error(ctrl_dec_error),
      .done_valid(done_valid), .done_rd(done_rd),
      .sb_empty(sb_empty)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   typedef struct {
      logic [31:0] ins;
      logic        exp_proc;
      logic        exp_err;
      logic        exp_set;
   } vec_t;

   vec_t vecs[12];

   localparam logic [31:0] ADDI_X1  = 32'h00100093;
   localparam logic [31:0] ADDI_X2  = 32'h00200113;
   localparam logic [31:0] ADDI_X3  = 32'h00300193;
   localparam logic [31:0] ADDI_X5  = 32'h00500293;
   localparam logic [31:0] ADDI_X9  = 32'h00900493;
   localparam logic [31:0] ADD_X6   = 32'h00328333;
   localparam logic [31:0] LW_X7    = 32'h00002383;
   localparam logic [31:0] FENCE    = 32'h0000000F;
   localparam logic [31:0] BEQ      = 32'h00000063;
   localparam logic [31:0] NOP      = 32'h00000013;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // from just after a rising edge to the sampling point
   task automatic mid();
      @(negedge aclk);
   endtask

   // to just after the next rising edge
   task automatic cyc();
      @(posedge aclk);
      #1;
   endtask

   task automatic offer(input logic [31:0] i, input logic [31:0] pc);
      inst_valid = 1'b1;
      inst       = i;
      inst_pc    = pc;
   endtask

   initial begin
      vecs[0]  = '{32'h00100093, 1'b1, 1'b0, 1'b1}; // addi x1,x0,1
      vecs[1]  = '{32'h00000013, 1'b1, 1'b0, 1'b0}; // nop (rd=x0)
      vecs[2]  = '{32'h00002383, 1'b1, 1'b0, 1'b1}; // lw x7,0(x0)
      vecs[3]  = '{32'h00202023, 1'b1, 1'b0, 1'b0}; // sw x2,0(x0)
      vecs[4]  = '{32'h002081B3, 1'b1, 1'b0, 1'b1}; // add x3,x1,x2
      vecs[5]  = '{32'h00001237, 1'b0, 1'b0, 1'b0}; // lui x4,1
      vecs[6]  = '{32'h000000EF, 1'b0, 1'b0, 1'b0}; // jal x1,0
      vecs[7]  = '{32'h00000063, 1'b0, 1'b0, 1'b0}; // beq x0,x0,0
      vecs[8]  = '{32'h00000073, 1'b0, 1'b0, 1'b0}; // ecall
      vecs[9]  = '{32'h0000000F, 1'b0, 1'b0, 1'b0}; // fence
      vecs[10] = '{32'h0000007F, 1'b0, 1'b1, 1'b0}; // illegal
      vecs[11] = '{32'h0000000B, 1'b0, 1'b1, 1'b0}; // custom-0, unsupported

      arst = 1'b1; flush = 1'b0; inst_valid = 1'b0; inst = '0; inst_pc = '0;
      proc_ready = 1'b0; ctrl_ready = 1'b0; done_valid = 1'b0; done_rd = '0;

      // reset state
      repeat (2) @(posedge aclk);
      mid();
      chk("rst proc_valid", proc_valid, 0);
      chk("rst ctrl_valid", ctrl_valid, 0);
      chk("rst issue_inst", issue_inst, 0);
      chk("rst issue_pc", issue_pc, 0);
      chk("rst dec_error", ctrl_dec_error, 0);
      chk("rst sb_empty", sb_empty, 1);
      cyc();
      arst = 1'b0;
      mid();
      chk("post-rst inst_ready", inst_ready, 1);
      cyc();

      // table: classify, issue, scoreboard set/clear
      for (int k = 0; k < 12; k++) begin
         offer(vecs[k].ins, 32'h1000 + 32'(k * 4));
         proc_ready = 1'b0; ctrl_ready = 1'b0;
         mid();
         chk($sformatf("v%0d inst_ready", k), inst_ready, 1);
         cyc();
         inst_valid = 1'b0;
         proc_ready = 1'b1; ctrl_ready = 1'b1;
         mid();
         chk($sformatf("v%0d proc_valid", k), proc_valid, vecs[k].exp_proc);
         chk($sformatf("v%0d ctrl_valid", k), ctrl_valid, !vecs[k].exp_proc);
         chk($sformatf("v%0d dec_error", k), ctrl_dec_error, vecs[k].exp_err);
         chk($sformatf("v%0d issue_inst", k), issue_inst, vecs[k].ins);
         chk($sformatf("v%0d issue_pc", k), issue_pc, 32'h1000 + 32'(k * 4));
         chk($sformatf("v%0d fire ready", k), inst_ready, 1);
         cyc();
         proc_ready = 1'b0; ctrl_ready = 1'b0;
         done_valid = 1'b1; done_rd = vecs[k].ins[11:7];
         mid();
         chk($sformatf("v%0d proc_valid off", k), proc_valid, 0);
         chk($sformatf("v%0d ctrl_valid off", k), ctrl_valid, 0);
         chk($sformatf("v%0d sb_empty", k), sb_empty, !vecs[k].exp_set);
         cyc();
         done_valid = 1'b0;
         mid();
         chk($sformatf("v%0d sb_empty cleared", k), sb_empty, 1);
         cyc();
      end

      // back-to-back independent stream
      offer(ADDI_X1, 32'h100); proc_ready = 1'b1;
      cyc();
      offer(ADDI_X2, 32'h104);
      mid();
      chk("b2b first valid", proc_valid, 1);
      chk("b2b first inst", issue_inst, ADDI_X1);
      chk("b2b ready", inst_ready, 1);
      cyc();
      inst_valid = 1'b0;
      mid();
      chk("b2b second valid", proc_valid, 1);
      chk("b2b second inst", issue_inst, ADDI_X2);
      chk("b2b second pc", issue_pc, 32'h104);
      chk("b2b sb busy", sb_empty, 0);
      cyc();
      proc_ready = 1'b0; done_valid = 1'b1; done_rd = 5'd1;
      mid();
      chk("b2b idle", proc_valid, 0);
      cyc();
      done_rd = 5'd2;
      mid();
      chk("b2b x2 still busy", sb_empty, 0);
      cyc();
      done_valid = 1'b0;
      mid();
      chk("b2b sb empty", sb_empty, 1);
      cyc();

      // RAW hazard on x5
      offer(ADDI_X5, 32'h200); proc_ready = 1'b1;
      cyc();
      offer(ADD_X6, 32'h204);
      cyc();
      offer(NOP, 32'h208);
      for (int k = 0; k < 3; k++) begin
         mid();
         chk($sformatf("raw stall valid %0d", k), proc_valid, 0);
         chk($sformatf("raw stall ready %0d", k), inst_ready, 0);
         chk($sformatf("raw held inst %0d", k), issue_inst, ADD_X6);
         cyc();
      end
      done_valid = 1'b1; done_rd = 5'd5;
      mid();
      chk("raw done cycle valid", proc_valid, 0);
      cyc();
      done_valid = 1'b0; inst_valid = 1'b0;
      mid();
      chk("raw valid after done", proc_valid, 1);
      chk("raw ready on fire", inst_ready, 1);
      cyc();
      proc_ready = 1'b0; done_valid = 1'b1; done_rd = 5'd6;
      mid();
      chk("raw x6 busy", sb_empty, 0);
      cyc();
      done_valid = 1'b0;
      mid();
      chk("raw sb empty", sb_empty, 1);
      cyc();

      // fence drains behind an outstanding load
      offer(LW_X7, 32'h300); proc_ready = 1'b1; ctrl_ready = 1'b1;
      cyc();
      offer(FENCE, 32'h304);
      mid();
      chk("drain lw valid", proc_valid, 1);
      cyc();
      inst_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         mid();
         chk($sformatf("drain hold %0d", k), ctrl_valid, 0);
         chk($sformatf("drain sb %0d", k), sb_empty, 0);
         chk($sformatf("drain inst %0d", k), issue_inst, FENCE);
         cyc();
      end
      done_valid = 1'b1; done_rd = 5'd7;
      mid();
      chk("drain done cycle", ctrl_valid, 0);
      cyc();
      done_valid = 1'b0;
      mid();
      chk("drain release", ctrl_valid, 1);
      chk("drain sb empty", sb_empty, 1);
      cyc();
      proc_ready = 1'b0; ctrl_ready = 1'b0;
      mid();
      chk("drain issued", ctrl_valid, 0);
      cyc();

      // flush a held branch under backpressure, busy bit kept
      offer(ADDI_X1, 32'h400); proc_ready = 1'b1;
      cyc();
      offer(BEQ, 32'h404);
      cyc();
      inst_valid = 1'b0; proc_ready = 1'b0;
      mid();
      chk("flush branch valid", ctrl_valid, 1);
      cyc();
      flush = 1'b1; offer(NOP, 32'h408);
      mid();
      chk("flush ready low", inst_ready, 0);
      chk("flush cycle valid", ctrl_valid, 1);
      cyc();
      flush = 1'b0; inst_valid = 1'b0;
      mid();
      chk("flush valid dropped", ctrl_valid, 0);
      chk("flush no new inst", proc_valid, 0);
      chk("flush busy kept", sb_empty, 0);
      chk("flush ready back", inst_ready, 1);
      cyc();
      done_valid = 1'b1; done_rd = 5'd1;
      cyc();
      done_valid = 1'b0;
      mid();
      chk("flush sb cleared", sb_empty, 1);
      cyc();

      // flush coinciding with a processing issue still sets the scoreboard
      offer(ADDI_X3, 32'h500); proc_ready = 1'b1;
      cyc();
      inst_valid = 1'b0; flush = 1'b1;
      mid();
      chk("flush+fire valid", proc_valid, 1);
      chk("flush+fire ready", inst_ready, 0);
      cyc();
      flush = 1'b0; proc_ready = 1'b0;
      mid();
      chk("flush+fire idle", proc_valid, 0);
      chk("flush+fire busy", sb_empty, 0);
      cyc();
      done_valid = 1'b1; done_rd = 5'd3;
      cyc();
      done_valid = 1'b0;
      mid();
      chk("flush+fire cleared", sb_empty, 1);
      cyc();

      // backpressure then asynchronous reset mid-stall
      offer(ADDI_X1, 32'h600); proc_ready = 1'b1;
      cyc();
      offer(ADDI_X9, 32'h2000);
      cyc();
      inst_valid = 1'b0; proc_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         mid();
         chk($sformatf("bp valid %0d", k), proc_valid, 1);
         chk($sformatf("bp inst %0d", k), issue_inst, ADDI_X9);
         chk($sformatf("bp pc %0d", k), issue_pc, 32'h2000);
         chk($sformatf("bp sb %0d", k), sb_empty, 0);
         cyc();
      end
      arst = 1'b1;
      #1;
      chk("arst proc_valid", proc_valid, 0);
      chk("arst ctrl_valid", ctrl_valid, 0);
      chk("arst issue_inst", issue_inst, 0);
      chk("arst issue_pc", issue_pc, 0);
      chk("arst dec_error", ctrl_dec_error, 0);
      chk("arst sb_empty", sb_empty, 1);
      cyc();
      arst = 1'b0;
      mid();
      chk("arst release ready", inst_ready, 1);
      chk("arst release valid", proc_valid, 0);
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
